// File: rtl/write_coalesce_buf_pkg.sv
// write_buf_pkg: shared types and helpers for the coalescing write buffer.
// line_t is sized for the default 20-bit address / 512-bit CCI line.
package write_buf_pkg;

   localparam int LINE_AW = 20;
   localparam int LINE_DW = 512;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   typedef struct packed {
      logic [LINE_AW-1:0] addr;
      logic [LINE_DW-1:0] data;
   } line_t;

   function automatic int widx(input int cache_w, input int word_w);
      return $clog2(cache_w / word_w);
   endfunction

endpackage

// File: rtl/write_coalesce_buf_if.sv
// write_coalesce_buf_if: CCI write request / dual response channel bundle.
// master = the buffer issuing writes, slave = the CCI side.
interface write_coalesce_buf_if #(
   parameter int ADDR_LMT    = 20,
   parameter int MDATA       = 14,
   parameter int CACHE_WIDTH = 512
);

   logic [ADDR_LMT-1:0]    wr_req_addr;
   logic [MDATA-1:0]       wr_req_mdata;
   logic [CACHE_WIDTH-1:0] wr_req_data;
   logic                   wr_req_en;
   logic                   wr_req_almostfull;
   logic                   wr_rsp0_valid;
   logic [MDATA-1:0]       wr_rsp0_mdata;
   logic                   wr_rsp1_valid;
   logic [MDATA-1:0]       wr_rsp1_mdata;

   modport master (
      output wr_req_addr,
      output wr_req_mdata,
      output wr_req_data,
      output wr_req_en,
      input  wr_req_almostfull,
      input  wr_rsp0_valid,
      input  wr_rsp0_mdata,
      input  wr_rsp1_valid,
      input  wr_rsp1_mdata
   );

   modport slave (
      input  wr_req_addr,
      input  wr_req_mdata,
      input  wr_req_data,
      input  wr_req_en,
      output wr_req_almostfull,
      output wr_rsp0_valid,
      output wr_rsp0_mdata,
      output wr_rsp1_valid,
      output wr_rsp1_mdata
   );

endinterface

// File: rtl/write_coalesce_buf_line_fifo.sv
// line_fifo: DEPTH-entry synchronous FIFO holding closed cache lines.
// The head entry is presented combinationally on o_data while non-empty.
module line_fifo #(
   parameter int  W     = 532,
   parameter int  DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic [AW:0]  o_count,
   output logic         o_full,
   output logic         o_empty
);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [AW:0]   r_cnt;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_cnt == (AW+1)'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_data  = r_mem[r_rp];
   assign o_count = r_cnt;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wp] <= i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop)  r_rp <= r_rp + AW'(1);
         r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end

endmodule

// File: rtl/write_coalesce_buf.sv
// write_coalesce_buf: merges word writes into CCI cache-line writes.
// Define WRITE_COALESCE_BUF_STATS_EN to add stat_lines/stat_partial outputs.
module write_coalesce_buf
   import write_buf_pkg::*;
#(
   parameter int  ADDR_LMT        = 20,
   parameter int  MDATA           = 14,
   parameter int  CACHE_WIDTH     = 512,
   parameter int  WORD_WIDTH      = 32,
   parameter int  DEPTH           = 4,
   parameter int  MAX_OUTSTANDING = 32,
   localparam int WIDX            = widx(CACHE_WIDTH, WORD_WIDTH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     wr_en,
   input  logic [ADDR_LMT+WIDX-1:0] wr_addr,
   input  logic [WORD_WIDTH-1:0]    wr_data,
   input  logic                     wr_now,
   output logic                     wr_ready,
   output logic                     wr_drained,
   write_coalesce_buf_if.master     cci
`ifdef WRITE_COALESCE_BUF_STATS_EN
   ,
   output logic [31:0]              stat_lines,
   output logic [31:0]              stat_partial
`endif
);

   localparam int LW = ADDR_LMT + CACHE_WIDTH;
   localparam int QW = $clog2(DEPTH) + 1;
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [OW-1:0] MAX_O     = OW'(MAX_OUTSTANDING);
   localparam logic [QW-1:0] READY_LIM = QW'(DEPTH - 2);

   state_e                 r_state;
   state_e                 w_state_nxt;
   logic                   r_open_vld;
   logic                   w_open_vld_nxt;
   logic [ADDR_LMT-1:0]    r_open_addr;
   logic [ADDR_LMT-1:0]    w_open_addr_nxt;
   logic [CACHE_WIDTH-1:0] r_open_data;
   logic [CACHE_WIDTH-1:0] w_open_data_nxt;
   logic [CACHE_WIDTH-1:0] w_merged;
   logic [CACHE_WIDTH-1:0] w_fresh;
   logic [ADDR_LMT-1:0]    w_line;
   logic [WIDX-1:0]        w_idx;
   logic                   w_run;
   logic                   w_acc;
   logic                   w_diff;
   logic                   w_last;
   logic                   w_push;
   logic [LW-1:0]          w_push_line;
   logic [LW-1:0]          w_head;
   logic [QW-1:0]          w_cnt;
   logic [QW-1:0]          w_cnt_nxt;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_issue;
   logic                   w_rsp0;
   logic                   w_rsp1;
   logic [OW-1:0]          r_out;
   logic [OW-1:0]          w_out_nxt;
   logic [OW:0]            w_sum;
   logic [OW:0]            w_dec;
   logic [MDATA-1:0]       r_tag;
   logic                   r_req_en;
   logic [ADDR_LMT-1:0]    r_req_addr;
   logic [MDATA-1:0]       r_req_mdata;
   logic [CACHE_WIDTH-1:0] r_req_data;
   logic                   r_drained;
   logic                   w_unused_mdata;

   assign w_run    = (r_state == RUN);
   assign wr_ready = w_run & (w_cnt <= READY_LIM);
   assign w_acc    = wr_en & wr_ready;
   assign w_line   = wr_addr[ADDR_LMT+WIDX-1:WIDX];
   assign w_idx    = wr_addr[WIDX-1:0];
   assign w_last   = &w_idx;
   assign w_diff   = w_acc & r_open_vld & (w_line != r_open_addr);

   assign w_issue  = w_run & ~w_empty & ~cci.wr_req_almostfull
                   & (r_out < MAX_O);
   assign w_rsp0   = w_run & cci.wr_rsp0_valid;
   assign w_rsp1   = w_run & cci.wr_rsp1_valid;

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (start) w_state_nxt = RUN;
         RUN:     w_state_nxt = RUN;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_merged = r_open_data;
      w_merged[WORD_WIDTH*w_idx +: WORD_WIDTH] = wr_data;
      w_fresh = '0;
      w_fresh[WORD_WIDTH*w_idx +: WORD_WIDTH] = wr_data;
   end

   // Close priority: line switch, then last word, then flush request.
   always_comb begin
      w_push          = 1'b0;
      w_push_line     = {r_open_addr, r_open_data};
      w_open_vld_nxt  = r_open_vld;
      w_open_addr_nxt = r_open_addr;
      w_open_data_nxt = r_open_data;
      if (w_diff) begin
         w_push          = 1'b1;
         w_open_vld_nxt  = 1'b1;
         w_open_addr_nxt = w_line;
         w_open_data_nxt = w_fresh;
      end else if (w_acc && (w_last || wr_now)) begin
         w_push          = 1'b1;
         w_push_line     = {w_line, w_merged};
         w_open_vld_nxt  = 1'b0;
         w_open_data_nxt = '0;
      end else if (w_acc) begin
         w_open_vld_nxt  = 1'b1;
         w_open_addr_nxt = w_line;
         w_open_data_nxt = w_merged;
      end else if (w_run && wr_now && r_open_vld) begin
         w_push          = 1'b1;
         w_open_vld_nxt  = 1'b0;
         w_open_data_nxt = '0;
      end
   end

   assign w_cnt_nxt = w_cnt + QW'(w_push & ~w_full) - QW'(w_issue);

   assign w_sum     = {1'b0, r_out} + (OW+1)'(w_issue);
   assign w_dec     = (OW+1)'(w_rsp0) + (OW+1)'(w_rsp1);
   assign w_out_nxt = (w_sum < w_dec) ? '0 : OW'(w_sum - w_dec);

   line_fifo #(
      .W     (LW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  (w_push_line),
      .i_pop   (w_issue),
      .o_data  (w_head),
      .o_count (w_cnt),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_open_vld  <= 1'b0;
         r_open_addr <= '0;
         r_open_data <= '0;
         r_out       <= '0;
         r_tag       <= '0;
         r_req_en    <= 1'b0;
         r_req_addr  <= '0;
         r_req_mdata <= '0;
         r_req_data  <= '0;
         r_drained   <= 1'b0;
      end else begin
         r_open_vld  <= w_open_vld_nxt;
         r_open_addr <= w_open_addr_nxt;
         r_open_data <= w_open_data_nxt;
         r_out       <= w_out_nxt;
         r_req_en    <= w_issue;
         r_drained   <= (w_state_nxt == RUN) & ~w_open_vld_nxt
                      & (w_cnt_nxt == '0) & (w_out_nxt == '0);
         if (w_issue) begin
            r_req_addr  <= w_head[LW-1:CACHE_WIDTH];
            r_req_data  <= w_head[CACHE_WIDTH-1:0];
            r_req_mdata <= r_tag;
            r_tag       <= r_tag + MDATA'(1);
         end
      end
   end

   // More responses than outstanding writes is a protocol error upstream.
   a_rsp_underflow: assert property (
      @(posedge clk) disable iff (reset) w_sum >= w_dec
   );

   assign cci.wr_req_en    = r_req_en;
   assign cci.wr_req_addr  = r_req_addr;
   assign cci.wr_req_mdata = r_req_mdata;
   assign cci.wr_req_data  = r_req_data;
   assign wr_drained       = r_drained;
   assign w_unused_mdata   = ^{cci.wr_rsp0_mdata, cci.wr_rsp1_mdata};

`ifdef WRITE_COALESCE_BUF_STATS_EN
   logic        w_part;
   logic [31:0] r_stat_lines;
   logic [31:0] r_stat_partial;

   assign w_part = w_push & ~(w_acc & ~w_diff & w_last);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stat_lines   <= '0;
         r_stat_partial <= '0;
      end else begin
         r_stat_lines   <= r_stat_lines + 32'(w_issue);
         r_stat_partial <= r_stat_partial + 32'(w_part);
      end
   end

   assign stat_lines   = r_stat_lines;
   assign stat_partial = r_stat_partial;
`endif

endmodule

// File: tb/tb_write_coalesce_buf.sv
// tb_write_coalesce_buf: directed scenarios plus random traffic, each cycle
// compared against a line-level reference model of the buffer.
module tb_write_coalesce_buf;
   import write_buf_pkg::*;

   localparam int AL    = 20;
   localparam int MD    = 14;
   localparam int CW    = 512;
   localparam int WW    = 32;
   localparam int WX    = 4;
   localparam int NW    = CW / WW;
   localparam int DEPTH = 4;
   localparam int MAXO  = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          wr_en;
   logic [AL+WX-1:0] wr_addr;
   logic [WW-1:0] wr_data;
   logic          wr_now;
   logic          wr_ready;
   logic          wr_drained;
`ifdef WRITE_COALESCE_BUF_STATS_EN
   logic [31:0]   stat_lines;
   logic [31:0]   stat_partial;
`endif

   write_coalesce_buf_if #(
      .ADDR_LMT(AL), .MDATA(MD), .CACHE_WIDTH(CW)
   ) cci ();

   write_coalesce_buf #(
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_now       (wr_now),
      .wr_ready     (wr_ready),
      .wr_drained   (wr_drained),
      .cci          (cci)
`ifdef WRITE_COALESCE_BUF_STATS_EN
      ,
      .stat_lines   (stat_lines),
      .stat_partial (stat_partial)
`endif
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int n_req  = 0;
   bit auto_rsp;

   task automatic check_eq(input string tag, input logic [CW-1:0] got,
                           input logic [CW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h want=%0h", tag, got, exp);
      end
   endtask

   // Reference model: open line as a word array, closed lines as a queue.
   bit            m_run;
   bit            m_open;
   logic [AL-1:0] m_addr;
   logic [WW-1:0] m_words [NW];
   line_t         m_q [$];
   int            m_out;
   int            m_tag;
   int            m_lines;
   int            m_part;
   bit            e_en;
   line_t         e_line;
   int            e_tag;

   function automatic void m_begin(input logic [AL-1:0] a);
      m_addr = a;
      for (int k = 0; k < NW; k++) m_words[k] = '0;
      m_open = 1'b1;
   endfunction

   function automatic void m_close(input bit partial);
      line_t l;
      l.addr = m_addr;
      for (int k = 0; k < NW; k++) l.data[k*WW +: WW] = m_words[k];
      m_q.push_back(l);
      m_open = 1'b0;
      if (partial) m_part++;
   endfunction

   task automatic step();
      bit rdy;
      bit acc;
      bit issue;
      int idx;
      logic [AL-1:0] ln;
      rdy = 1'b0;
      if (auto_rsp) begin
         cci.wr_rsp0_valid = (m_out > 0);
         cci.wr_rsp1_valid = 1'b0;
      end
      e_en = 1'b0;
      if (reset) begin
         m_run = 0; m_open = 0; m_q.delete();
         m_out = 0; m_tag = 0; m_lines = 0; m_part = 0;
      end else begin
         rdy = m_run && (m_q.size() <= DEPTH - 2);
         check_eq("wr_ready", wr_ready, rdy);
         issue = m_run && m_q.size() > 0 && !cci.wr_req_almostfull
               && m_out < MAXO;
         if (issue) begin
            e_en   = 1'b1;
            e_line = m_q.pop_front();
            e_tag  = m_tag;
            m_tag  = (m_tag + 1) % (1 << MD);
            m_lines++;
         end
         if (m_run) begin
            m_out = m_out + int'(issue) - int'(cci.wr_rsp0_valid)
                  - int'(cci.wr_rsp1_valid);
            if (m_out < 0) m_out = 0;
         end
         acc = wr_en && rdy;
         ln  = wr_addr[AL+WX-1:WX];
         idx = int'(wr_addr[WX-1:0]);
         if (acc && m_open && ln != m_addr) begin
            m_close(1'b1);
            m_begin(ln);
            m_words[idx] = wr_data;
         end else if (acc) begin
            if (!m_open) m_begin(ln);
            m_words[idx] = wr_data;
            if (idx == NW - 1) m_close(1'b0);
            else if (wr_now)   m_close(1'b1);
         end else if (m_run && wr_now && m_open) begin
            m_close(1'b1);
         end
         if (start) m_run = 1'b1;
      end
      @(posedge clk);
      #1;
      if (cci.wr_req_en === 1'b1) n_req++;
      check_eq("req_en", cci.wr_req_en, e_en);
      if (e_en) begin
         check_eq("req_addr", cci.wr_req_addr, e_line.addr);
         check_eq("req_mdata", cci.wr_req_mdata, e_tag);
         check_eq("req_data", cci.wr_req_data, e_line.data);
      end
      check_eq("drained", wr_drained,
               m_run && !m_open && m_q.size() == 0 && m_out == 0);
`ifdef WRITE_COALESCE_BUF_STATS_EN
      check_eq("stat_lines", stat_lines, m_lines);
      check_eq("stat_partial", stat_partial, m_part);
`endif
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic wr(input logic [AL-1:0] ln, input int idx,
                     input logic [WW-1:0] d, input bit now);
      wr_en   = 1'b1;
      wr_addr = {ln, WX'(idx)};
      wr_data = d;
      wr_now  = now;
      step();
      wr_en   = 1'b0;
      wr_now  = 1'b0;
   endtask

   task automatic flush();
      wr_now = 1'b1;
      step();
      wr_now = 1'b0;
   endtask

   task automatic restart();
      reset = 1'b1;
      cci.wr_req_almostfull = 1'b0;
      cci.wr_rsp0_valid = 1'b0;
      cci.wr_rsp1_valid = 1'b0;
      idle(2);
      reset = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      n_req = 0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; wr_en = 1'b0; wr_now = 1'b0;
      wr_addr = '0; wr_data = '0; auto_rsp = 1'b0;
      cci.wr_req_almostfull = 1'b0;
      cci.wr_rsp0_valid = 1'b0; cci.wr_rsp0_mdata = '0;
      cci.wr_rsp1_valid = 1'b0; cci.wr_rsp1_mdata = '0;
      idle(2);
      check_eq("rst_req_en", cci.wr_req_en, 0);
      check_eq("rst_req_addr", cci.wr_req_addr, 0);
      check_eq("rst_req_data", cci.wr_req_data, 0);
      check_eq("rst_ready", wr_ready, 0);
      check_eq("rst_drained", wr_drained, 0);

      // Sequential fill of line 0x00005.
      restart();
      auto_rsp = 1'b1;
      for (int k = 0; k < NW; k++) wr(20'h00005, k, WW'(k), 1'b0);
      idle(4);
      check_eq("fill_nreq", n_req, 1);
      check_eq("fill_drained", wr_drained, 1);

      // Partial flush, then flush of an empty line.
      restart();
      wr(20'h00010, 2, 32'hAAAA_0002, 1'b0);
      wr(20'h00010, 7, 32'hBBBB_0007, 1'b0);
      flush();
      idle(4);
      flush();
      idle(4);
      check_eq("part_nreq", n_req, 1);

      // Line switch closes the old line first.
      restart();
      wr(20'h00001, 3, 32'h1111_0003, 1'b0);
      wr(20'h00002, 0, 32'h2222_0000, 1'b0);
      flush();
      idle(5);
      check_eq("switch_nreq", n_req, 2);

      // Backpressure holds three queued lines.
      restart();
      cci.wr_req_almostfull = 1'b1;
      for (int l = 0; l < 3; l++) wr(AL'(32 + l), 0, $urandom, 1'b1);
      check_eq("bp_ready_low", wr_ready, 0);
      idle(3);
      check_eq("bp_nreq", n_req, 0);
      cci.wr_req_almostfull = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check_eq("bp_consec", cci.wr_req_en, 1);
      end
      idle(4);

      // Credit limit with no responses.
      restart();
      auto_rsp = 1'b0;
      for (int l = 0; l < 4; l++)
         for (int k = 0; k < NW; k++) wr(AL'(48 + l), k, $urandom, 1'b0);
      idle(4);
      check_eq("credit_nreq", n_req, 2);
      cci.wr_rsp0_valid = 1'b1; cci.wr_rsp1_valid = 1'b1;
      step();
      cci.wr_rsp0_valid = 1'b0; cci.wr_rsp1_valid = 1'b0;
      idle(4);
      check_eq("credit_nreq2", n_req, 4);
      cci.wr_rsp0_valid = 1'b1; cci.wr_rsp1_valid = 1'b1;
      step();
      cci.wr_rsp0_valid = 1'b0; cci.wr_rsp1_valid = 1'b0;
      step();
      check_eq("credit_drained", wr_drained, 1);

      // Reset with two lines queued and one outstanding.
      restart();
      wr(20'h00040, 0, 32'h4040_0000, 1'b1);
      idle(3);
      cci.wr_req_almostfull = 1'b1;
      wr(20'h00041, 0, 32'h4141_0000, 1'b1);
      wr(20'h00042, 0, 32'h4242_0000, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      cci.wr_req_almostfull = 1'b0;
      check_eq("mid_req_en", cci.wr_req_en, 0);
      check_eq("mid_req_addr", cci.wr_req_addr, 0);
      check_eq("mid_req_mdata", cci.wr_req_mdata, 0);
      check_eq("mid_drained", wr_drained, 0);
      n_req = 0;
      idle(5);
      check_eq("mid_nreq", n_req, 0);
      check_eq("mid_ready", wr_ready, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      check_eq("mid_restart", wr_drained, 1);

      // Random traffic over a small pool of lines.
      restart();
      for (int c = 0; c < 4000; c++) begin
         reset = ($urandom_range(0, 499) == 0);
         start = !m_run && ($urandom_range(0, 3) == 0);
         wr_en = ($urandom_range(0, 99) < 60);
         if ($urandom_range(0, 9) == 0)
            wr_addr = {AL'($urandom), WX'($urandom_range(0, NW - 1))};
         else
            wr_addr = {AL'($urandom_range(1, 3)),
                       WX'($urandom_range(0, NW - 1))};
         wr_data = $urandom;
         wr_now  = ($urandom_range(0, 9) == 0);
         cci.wr_req_almostfull = ($urandom_range(0, 3) == 0);
         cci.wr_rsp0_valid = (m_out > 0) && ($urandom_range(0, 2) == 0);
         cci.wr_rsp1_valid = (m_out > int'(cci.wr_rsp0_valid))
                           && ($urandom_range(0, 2) == 0);
         cci.wr_rsp0_mdata = MD'($urandom);
         cci.wr_rsp1_mdata = MD'($urandom);
         step();
      end
      reset = 1'b0; start = 1'b0; wr_en = 1'b0; wr_now = 1'b0;
      cci.wr_req_almostfull = 1'b0;
      auto_rsp = 1'b1;
      idle(20);

      $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/write_coalesce_buf.md
Name: write_coalesce_buf

Overview:
- Successor to the single-line CCI write buffer.
- Coalesces narrow word writes from the accelerator datapath into cache-line writes.
- Holds closed lines in a DEPTH-entry queue and issues them to the CCI write request channel.
- Tracks outstanding writes by counting both response channels, and reports drain completion for the control FSM.

Parameters:
- ADDR_LMT, 20, cache-line address width.
- MDATA, 14, request/response tag width.
- CACHE_WIDTH, 512, line width in bits.
- WORD_WIDTH, 32, input word width; CACHE_WIDTH/WORD_WIDTH is a power of two ≥ 2.
- DEPTH, 4, closed-line queue entries; power of two ≥ 2.
- MAX_OUTSTANDING, 32, cap on issued-but-unacknowledged writes.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; leaves IDLE.
- wr_en  in  1  word write strobe; accepted only when wr_ready=1.
- wr_addr  in  ADDR_LMT+WIDX  word address; WIDX=log2(CACHE_WIDTH/WORD_WIDTH).
- wr_data  in  WORD_WIDTH  word data.
- wr_now  in  1  flush request for the open line.
- wr_ready  out  1  input can be accepted this cycle.
- wr_drained  out  1  open line empty, queue empty, outstanding=0, state RUN.
- wr_req_addr  out  ADDR_LMT  line address to CCI.
- wr_req_mdata  out  MDATA  tag to CCI.
- wr_req_data  out  CACHE_WIDTH  line data to CCI.
- wr_req_en  out  1  one-cycle request strobe.
- wr_req_almostfull  in  1  CCI backpressure.
- wr_rsp0_valid  in  1  write response on channel 0.
- wr_rsp0_mdata  in  MDATA  tag for channel 0.
- wr_rsp1_valid  in  1  write response on channel 1.
- wr_rsp1_mdata  in  MDATA  tag for channel 1.

Behaviour:
- FSM states: IDLE → RUN on start. RUN is permanent until reset. In IDLE, wr_ready=0 and responses are ignored.
- Reset, any state including mid-operation:
  - state=IDLE; all wr_req_* =0; wr_ready=0; wr_drained=0.
  - Open line cleared (valid=0, data=0); queue emptied; outstanding=0; tag counter=0.
  - Queued lines are discarded.
- Open line: holds line address, data, and open flag. Accepted word index i=wr_addr[WIDX-1:0] writes data[i*WORD_WIDTH +: WORD_WIDTH]. Unwritten words are zero.
- Close rules, in priority order within one cycle:
  - (a) Accepted word to a different line address than the open line: close the old line into the queue, then open the new line containing this word.
  - (b) Accepted word with i = last index: close the line including this word.
  - (c) wr_now with an open, non-empty line: close it. wr_now on an empty line is a no-op.
  - When wr_now and a write occur together, the word lands first and then the line closes.
- At most one push per cycle. Rule (a) combined with a last-index word keeps the new line open; it closes on a later event.
- wr_ready = RUN & queue count ≤ DEPTH-2 (room for one push plus margin); combinational from registered state.
- Issue: when queue non-empty, !wr_req_almostfull and outstanding < MAX_OUTSTANDING:
  - Pop the head into the registered wr_req_* on the next edge, with wr_req_en=1 for exactly one cycle.
  - wr_req_mdata = tag counter; the counter increments and wraps at 2^MDATA.
  - Latency from push (empty queue, no backpressure) to wr_req_en = 2 cycles.
  - Push and pop in the same cycle are legal.
- Outstanding counter:
  - +1 per issue; -1 per rsp0_valid; -1 per rsp1_valid.
  - Issue and two responses in one cycle net -1.
  - Underflow saturates at 0. This is a protocol error; assertion only in simulation.
- wr_drained is registered, so it updates one cycle after the last response.

Optional Feature:
- Macro WRITE_COALESCE_BUF_STATS_EN.
- With the macro defined, the block adds:
  - output stat_lines (32 bits): count of issued lines.
  - output stat_partial (32 bits): count of lines closed by rule (a) or (c).
  - Both counters clear on reset and wrap.
- Without the macro: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package write_buf_pkg:
  - WIDX computation function.
  - State enum (IDLE, RUN).
  - Line struct {addr, data}.
- Sub-module line_fifo: a DEPTH × (ADDR_LMT+CACHE_WIDTH) synchronous FIFO with push, pop, count, full and empty. The top level holds the open-line, FSM, tag and credit logic.

Test Plan:
- Sequential fill: start, then 16 words to line 0x00005 indices 0..15, data=index. Required: one wr_req_en, addr=0x00005, mdata=0, word k=k. wr_drained=1 after one rsp0.
- Partial flush: words at indices 2 and 7 of line 0x10, then wr_now. Required: data has word2 and word7 set, all other words 0. wr_now again with the line empty: no request.
- Line switch: word i=3 to line 0x1, then i=0 to line 0x2, then wr_now. Required: two requests in order 0x1 then 0x2, mdata 0 then 1.
- Backpressure: hold wr_req_almostfull=1 while closing 3 lines at DEPTH=4. Required: wr_ready falls at count 3 and no wr_req_en. After release, 3 requests on consecutive cycles.
- Credit limit: MAX_OUTSTANDING=2, 4 full lines, no responses. Required: exactly 2 issued. rsp0 and rsp1 in the same cycle release both remaining lines; wr_drained follows the final responses.
- Reset mid-operation: assert reset with 2 lines queued and 1 outstanding. Required: all outputs 0, no further requests, and IDLE until the next start.
